// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer.
//   - ROM entry layout {note[3:0], dur[3:0]} and note codes
//   - note frequency table and half-period helper (elaboration-time only)
//   - sequencer state encoding
package tone_pkg;

    localparam int NOTE_W  = 4;
    localparam int DUR_W   = 4;
    localparam int ENTRY_W = NOTE_W + DUR_W;

    localparam logic [NOTE_W-1:0] NOTE_REST     = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4       = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_CS4      = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_D4       = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_DS4      = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_E4       = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_F4       = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_FS4      = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_G4       = 4'd8;
    localparam logic [NOTE_W-1:0] NOTE_GS4      = 4'd9;
    localparam logic [NOTE_W-1:0] NOTE_A4       = 4'd10;
    localparam logic [NOTE_W-1:0] NOTE_AS4      = 4'd11;
    localparam logic [NOTE_W-1:0] NOTE_B4       = 4'd12;
    localparam logic [NOTE_W-1:0] NOTE_C5       = 4'd13;
    localparam logic [NOTE_W-1:0] NOTE_REST_ALT = 4'd14;
    localparam logic [NOTE_W-1:0] NOTE_END      = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Returns 0 for rests and the end marker.
    function automatic int note_hz(input logic [NOTE_W-1:0] note);
        case (note)
            4'd1:    return 262;
            4'd2:    return 277;
            4'd3:    return 294;
            4'd4:    return 311;
            4'd5:    return 330;
            4'd6:    return 349;
            4'd7:    return 370;
            4'd8:    return 392;
            4'd9:    return 415;
            4'd10:   return 440;
            4'd11:   return 466;
            4'd12:   return 494;
            4'd13:   return 523;
            default: return 0;
        endcase
    endfunction

    function automatic int half_period(input int clk_hz, input logic [NOTE_W-1:0] note);
        int hz;
        hz = note_hz(note);
        if (hz == 0) return 0;
        return clk_hz / (2 * hz);
    endfunction

endpackage

// File: rtl/tune_rom.sv
// Combinational note ROM addressed by {tune, index}.
//   i_tune  : tune number
//   i_idx   : entry index within the tune
//   o_entry : {note, dur}; anything not listed reads as the end marker
module tune_rom
    import tone_pkg::*;
#(
    parameter int NUM_TUNES = 4,
    parameter int TUNE_LEN  = 8
) (
    input  logic [$clog2(NUM_TUNES)-1:0] i_tune,
    input  logic [$clog2(TUNE_LEN)-1:0]  i_idx,
    output logic [ENTRY_W-1:0]           o_entry
);

    always_comb begin
        o_entry = {NOTE_END, 4'd0};
        case (int'(i_tune))
            0: begin                                   // move
                case (int'(i_idx))
                    0:       o_entry = {NOTE_A4, 4'd0};
                    default: ;
                endcase
            end
            1: begin                                   // win
                case (int'(i_idx))
                    0:       o_entry = {NOTE_C4, 4'd1};
                    1:       o_entry = {NOTE_E4, 4'd1};
                    2:       o_entry = {NOTE_G4, 4'd1};
                    3:       o_entry = {NOTE_C5, 4'd3};
                    default: ;
                endcase
            end
            2: begin                                   // lose
                case (int'(i_idx))
                    0:       o_entry = {NOTE_G4, 4'd1};
                    1:       o_entry = {NOTE_REST, 4'd0};
                    2:       o_entry = {NOTE_C4, 4'd3};
                    default: ;
                endcase
            end
            3: begin                                   // draw
                case (int'(i_idx))
                    0:       o_entry = {NOTE_E4, 4'd1};
                    1:       o_entry = {NOTE_E4, 4'd1};
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tone_sequencer.sv
// Square-wave tune player driving the piezo speaker.
//   clk, rst (async, active-low)
//   play, tune_sel : one-cycle start request and the tune it selects
//   stop           : abort the running tune (no done pulse)
//   mute           : silence the speaker without affecting sequencing
//   speaker        : registered square-wave output
//   busy, done     : busy outside IDLE; done pulses for one cycle on normal completion
//
// state | meaning
// IDLE  | waiting for play
// FETCH | read ROM entry, load note timing (speaker low)
// PLAY  | divide clock into tone, count note duration
// DONE  | one-cycle completion pulse
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 16,
    parameter int NUM_TUNES = 4,
    parameter int TUNE_LEN  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         play,
    input  logic [$clog2(NUM_TUNES)-1:0] tune_sel,
    input  logic                         stop,
    input  logic                         mute,
    output logic                         speaker,
    output logic                         busy,
    output logic                         done
);

    localparam int TICK_CYC = CLK_HZ / TICK_HZ;
    localparam int DIV_W    = $clog2(CLK_HZ / (2 * 262) + 1);
    localparam int TICK_W   = $clog2(TICK_CYC * 16 + 1);
    localparam int TSEL_W   = $clog2(NUM_TUNES);
    localparam int IDX_W    = $clog2(TUNE_LEN);

    function automatic logic [15:0][DIV_W-1:0] build_half_tab();
        logic [15:0][DIV_W-1:0] t;
        for (int n = 0; n < 16; n++) t[n] = DIV_W'(half_period(CLK_HZ, 4'(n)));
        return t;
    endfunction

    localparam logic [15:0][DIV_W-1:0] HALF_TAB = build_half_tab();

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TSEL_W-1:0]    r_tune;
    logic [IDX_W-1:0]     r_idx;
    logic [ENTRY_W-1:0]   r_entry;
    logic [DIV_W-1:0]     r_half;
    logic [DIV_W-1:0]     r_div;
    logic [TICK_W-1:0]    r_tick;
    logic                 r_phase;
    logic                 r_speaker;

    logic [ENTRY_W-1:0]   w_rom_entry;
    logic [NOTE_W-1:0]    w_rom_note;
    logic [NOTE_W-1:0]    w_note;
    logic [DUR_W-1:0]     w_dur;
    logic                 w_rest;
    logic [TICK_W-1:0]    w_tick_end;
    logic                 w_tick_exp;
    logic                 w_last_idx;
    logic                 w_div_wrap;
    logic [DIV_W-1:0]     w_div_nxt;
    logic [TICK_W-1:0]    w_tick_nxt;
    logic                 w_phase_nxt;

    tune_rom #(
        .NUM_TUNES (NUM_TUNES),
        .TUNE_LEN  (TUNE_LEN)
    ) u_rom (
        .i_tune  (r_tune),
        .i_idx   (r_idx),
        .o_entry (w_rom_entry)
    );

    assign w_rom_note = w_rom_entry[ENTRY_W-1:DUR_W];
    assign w_note     = r_entry[ENTRY_W-1:DUR_W];
    assign w_dur      = r_entry[DUR_W-1:0];
    assign w_rest     = (w_note == NOTE_REST) || (w_note == NOTE_REST_ALT);
    assign w_tick_end = TICK_W'((int'(w_dur) + 1) * TICK_CYC - 1);
    assign w_tick_exp = (r_tick == w_tick_end);
    assign w_last_idx = (r_idx == IDX_W'(TUNE_LEN - 1));
    assign w_div_wrap = (r_div == r_half - DIV_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (play && !stop) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (stop)                        w_state_nxt = ST_IDLE;
                else if (w_rom_note == NOTE_END) w_state_nxt = ST_DONE;
                else                             w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (stop)            w_state_nxt = ST_IDLE;
                else if (w_tick_exp) w_state_nxt = w_last_idx ? ST_DONE : ST_FETCH;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Tone divider and duration counter; rests keep the divider parked at 0.
    always_comb begin
        w_div_nxt   = r_div;
        w_tick_nxt  = r_tick;
        w_phase_nxt = r_phase;
        if (r_state == ST_FETCH) begin
            w_div_nxt   = '0;
            w_tick_nxt  = '0;
            w_phase_nxt = 1'b0;
        end else if (r_state == ST_PLAY) begin
            w_tick_nxt = r_tick + TICK_W'(1);
            if (w_rest) begin
                w_div_nxt   = '0;
                w_phase_nxt = 1'b0;
            end else if (w_div_wrap) begin
                w_div_nxt   = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_div_nxt = r_div + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tune    <= '0;
            r_idx     <= '0;
            r_entry   <= '0;
            r_half    <= '0;
            r_div     <= '0;
            r_tick    <= '0;
            r_phase   <= 1'b0;
            r_speaker <= 1'b0;
        end else begin
            r_div   <= w_div_nxt;
            r_tick  <= w_tick_nxt;
            r_phase <= w_phase_nxt;
            if (r_state == ST_IDLE && play && !stop) begin
                r_tune <= tune_sel;
                r_idx  <= '0;
            end
            if (r_state == ST_FETCH) begin
                r_entry <= w_rom_entry;
                r_half  <= HALF_TAB[w_rom_note];
            end
            if (r_state == ST_PLAY && w_state_nxt == ST_FETCH) r_idx <= r_idx + IDX_W'(1);
            // Speaker follows the next phase so it changes on the same edge as the phase.
            r_speaker <= w_phase_nxt && (w_state_nxt == ST_PLAY) && !mute;
        end
    end

    assign speaker = r_speaker;
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

    localparam int CLK_HZ  = 1_000_000;
    localparam int TICK_HZ = 1000;
    localparam int TICK    = 1000;
    localparam int H_A4    = 1136;
    localparam int H_C4    = 1908;
    localparam int H_E4    = 1515;
    localparam int H_G4    = 1275;
    localparam int H_C5    = 956;

    logic       clk = 1'b0;
    logic       rst;
    logic       play, stop, mute;
    logic [1:0] tune_sel;
    logic       speaker, busy, done;
    logic       play2;
    logic [1:0] tune_sel2;
    logic       speaker2, busy2, done2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tone_sequencer #(
        .CLK_HZ (CLK_HZ), .TICK_HZ (TICK_HZ), .NUM_TUNES (4), .TUNE_LEN (8)
    ) dut (
        .clk (clk), .rst (rst), .play (play), .tune_sel (tune_sel), .stop (stop),
        .mute (mute), .speaker (speaker), .busy (busy), .done (done)
    );

    tone_sequencer #(
        .CLK_HZ (CLK_HZ), .TICK_HZ (TICK_HZ), .NUM_TUNES (4), .TUNE_LEN (2)
    ) dut2 (
        .clk (clk), .rst (rst), .play (play2), .tune_sel (tune_sel2), .stop (1'b0),
        .mute (1'b0), .speaker (speaker2), .busy (busy2), .done (done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] outs(input int which);
        return (which == 0) ? {speaker, busy, done} : {speaker2, busy2, done2};
    endfunction

    task automatic accept(input int which, input logic [1:0] sel);
        if (which == 0) begin play = 1'b1; tune_sel = sel; end
        else begin play2 = 1'b1; tune_sel2 = sel; end
        tick();
        play  = 1'b0;
        play2 = 1'b0;
    endtask

    // Checks every PLAY cycle of one note: waveform from PLAY entry, busy high, no done.
    task automatic note(input int which, input string tag, input int half, input int len,
                        input logic muted);
        int         bad;
        logic       exp_s;
        logic [2:0] o;
        bad = 0;
        for (int j = 0; j < len; j++) begin
            tick();
            exp_s = (half > 0) && !muted && (((j / half) % 2) == 1);
            o = outs(which);
            if (o !== {exp_s, 1'b1, 1'b0}) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic fetch(input int which, input string tag);
        tick();
        chk(tag, outs(which), 3'b010);
    endtask

    task automatic finish_tune(input int which, input string tag);
        tick();
        chk({tag, " end-fetch"}, outs(which), 3'b010);
        tick();
        chk({tag, " done"}, outs(which), 3'b011);
        tick();
        chk({tag, " idle"}, outs(which), 3'b000);
    endtask

    initial begin
        int seen;
        rst = 1'b1; play = 1'b0; stop = 1'b0; mute = 1'b0; tune_sel = 2'd0;
        play2 = 1'b0; tune_sel2 = 2'd0;

        // power-up reset, checked before the first clock edge
        #3 rst = 1'b0;
        #1 chk("por outputs", {speaker, busy, done}, 3'b000);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("post-reset idle", {speaker, busy, done}, 3'b000);

        // asynchronous reset 300 cycles into the first note of tune 1
        accept(0, 2'd1);
        repeat (300) tick();
        chk("pre-reset busy", {speaker, busy, done}, 3'b010);
        rst = 1'b0;
        #2 chk("async reset", {speaker, busy, done}, 3'b000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("reset release idle", {speaker, busy, done}, 3'b000);

        // tune 0: A4 for one tick, done at accept+1002..1003
        accept(0, 2'd0);
        chk("t0 accept", outs(0), 3'b010);
        note(0, "t0 A4", H_A4, TICK, 1'b0);
        finish_tune(0, "t0");

        // tune 2: G4, rest, C4
        accept(0, 2'd2);
        chk("t2 accept", outs(0), 3'b010);
        note(0, "t2 G4", H_G4, 2 * TICK, 1'b0);
        fetch(0, "t2 fetch1");
        note(0, "t2 rest", 0, TICK, 1'b0);
        fetch(0, "t2 fetch2");
        note(0, "t2 C4", H_C4, 4 * TICK, 1'b0);
        finish_tune(0, "t2");

        // tune 1 with a request for tune 3 while busy, and another during DONE
        accept(0, 2'd1);
        chk("t1 accept", outs(0), 3'b010);
        note(0, "t1 C4", H_C4, 2 * TICK, 1'b0);
        play = 1'b1; tune_sel = 2'd3;
        fetch(0, "t1 fetch1 ignore play");
        play = 1'b0;
        note(0, "t1 E4", H_E4, 2 * TICK, 1'b0);
        fetch(0, "t1 fetch2");
        note(0, "t1 G4", H_G4, 2 * TICK, 1'b0);
        fetch(0, "t1 fetch3");
        note(0, "t1 C5", H_C5, 4 * TICK, 1'b0);
        tick();
        chk("t1 end-fetch", outs(0), 3'b010);
        tick();
        chk("t1 done", outs(0), 3'b011);
        play = 1'b1; tune_sel = 2'd3;
        tick();
        play = 1'b0;
        chk("t1 play in DONE ignored", outs(0), 3'b000);
        tick();
        chk("t1 stays idle", outs(0), 3'b000);

        // tune 3 muted: silent, timing unchanged
        mute = 1'b1;
        accept(0, 2'd3);
        chk("t3 accept", outs(0), 3'b010);
        note(0, "t3 E4 muted", H_E4, 2 * TICK, 1'b1);
        fetch(0, "t3 fetch1");
        note(0, "t3 E4b muted", H_E4, 2 * TICK, 1'b1);
        finish_tune(0, "t3");
        mute = 1'b0;

        // stop 500 cycles into tune 1
        accept(0, 2'd1);
        repeat (500) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop t1", {speaker, busy, done}, 3'b000);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) seen++;
        end
        chk("stop no done", seen, 0);

        // stop while speaker is high
        accept(0, 2'd3);
        repeat (1600) tick();
        chk("t3 speaker high", speaker, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop clears speaker", {speaker, busy, done}, 3'b000);

        // stop in FETCH
        accept(0, 2'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop in fetch", {speaker, busy, done}, 3'b000);

        // stop wins over play in IDLE
        play = 1'b1; stop = 1'b1; tune_sel = 2'd0;
        tick();
        play = 1'b0; stop = 1'b0;
        chk("stop+play idle", {speaker, busy, done}, 3'b000);
        tick();
        chk("stop+play stays idle", {speaker, busy, done}, 3'b000);

        // TUNE_LEN=2: tune 1 plays only C4 and E4, then DONE directly
        accept(1, 2'd1);
        chk("len2 accept", outs(1), 3'b010);
        note(1, "len2 C4", H_C4, 2 * TICK, 1'b0);
        fetch(1, "len2 fetch1");
        note(1, "len2 E4", H_E4, 2 * TICK, 1'b0);
        tick();
        chk("len2 done", outs(1), 3'b011);
        tick();
        chk("len2 idle", outs(1), 3'b000);
        tick();
        chk("len2 no wrap", outs(1), 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
